// File: rtl/jk_pkg.sv
// Shared types, JK command encodings and the excitation lookup for the JK bank driver.
// Latency: n/a (declarations and a pure combinational function only).
// Backpressure: n/a.
package jk_pkg;

  // Controller state: IDLE accepts a target, DRIVE waits one cycle for the bank to respond.
  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

  // 2-bit {J,K} commands, matching the flip-flop case encoding.
  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  // Minimal excitation with don't-cares filled with 0: set on 0->1, reset on 1->0, hold otherwise.
  function automatic logic [1:0] excite(input logic q, input logic t);
    logic [1:0] cmd;
    case ({q, t})
      2'b01:   cmd = JK_SET;
      2'b10:   cmd = JK_RESET;
      default: cmd = JK_HOLD;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/jk_excite_bit.sv
// Per-bit JK excitation lookup from current Q and target bit; JK_TOGGLE_PREF_EN fills don't-cares with 1.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs continuously.
module jk_excite_bit
  import jk_pkg::*;
(
  input  logic q,
  input  logic t,
  output logic j,
  output logic k
);

  logic [1:0] cmd;

  // Look up the command; with toggle preference every bit that must change uses the toggle path.
  always_comb begin
    cmd = excite(q, t);
`ifdef JK_TOGGLE_PREF_EN
    if (cmd != JK_HOLD) begin
      cmd = JK_TOGGLE;
    end
`else
    cmd = cmd;
`endif
    {j, k} = cmd;
  end

endmodule

// File: rtl/jk_excitation_driver.sv
// Loads a target word into a negedge JK bank via J/K, verifies Q, retries up to MAX_RETRY, then DONE/ERR.
// Latency: DONE/ERR asserted at the posedge ending DRIVE, i.e. 1 + retries edges after the accept edge.
// Backpressure: TGT_READY high only in IDLE; TGT is ignored while busy. Optional macro: JK_TOGGLE_PREF_EN.
module jk_excitation_driver
  import jk_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_RETRY = 3,
  localparam int RETRY_W  = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1)
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [WIDTH-1:0]   TGT,
  input  logic               TGT_VALID,
  output logic               TGT_READY,
  input  logic [WIDTH-1:0]   Q_FB,
  output logic [WIDTH-1:0]   J,
  output logic [WIDTH-1:0]   K,
  output logic               DONE,
  output logic               ERR,
  output logic [WIDTH-1:0]   ERR_BITS,
  output logic [RETRY_W-1:0] RETRY_CNT
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   tgt_r, tgt_d;
  logic [WIDTH-1:0]   j_q, j_d, k_q, k_d;
  logic               done_q, done_d, err_q, err_d;
  logic [WIDTH-1:0]   err_bits_q, err_bits_d;
  logic [RETRY_W-1:0] retry_q, retry_d;

  logic [WIDTH-1:0]   exc_tgt;
  logic [WIDTH-1:0]   exc_j, exc_k;

  // In IDLE the excitation is for the incoming word; in DRIVE it re-targets the latched word.
  assign exc_tgt = (state_q == IDLE) ? TGT : tgt_r;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_exc
      jk_excite_bit u_exc (
        .q (Q_FB[gi]),
        .t (exc_tgt[gi]),
        .j (exc_j[gi]),
        .k (exc_k[gi])
      );
    end
  endgenerate

  // State and all registered outputs; reset forces J/K to hold so the bank stops immediately.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      tgt_r      <= '0;
      j_q        <= '0;
      k_q        <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_bits_q <= '0;
      retry_q    <= '0;
    end else begin
      state_q    <= state_d;
      tgt_r      <= tgt_d;
      j_q        <= j_d;
      k_q        <= k_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_bits_q <= err_bits_d;
      retry_q    <= retry_d;
    end
  end

  // Next state and next outputs; J/K default to hold so only DRIVE cycles ever carry a command.
  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_r;
    j_d        = '0;
    k_d        = '0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_bits_d = err_bits_q;
    retry_d    = retry_q;
    case (state_q)
      IDLE: begin
        if (TGT_VALID) begin
          tgt_d      = TGT;
          j_d        = exc_j;
          k_d        = exc_k;
          retry_d    = '0;
          err_bits_d = '0;
          state_d    = DRIVE;
        end
      end
      DRIVE: begin
        if (Q_FB == tgt_r) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
          retry_d = retry_q + RETRY_W'(1);
          j_d     = exc_j;
          k_d     = exc_k;
        end else begin
          err_d      = 1'b1;
          err_bits_d = Q_FB ^ tgt_r;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign TGT_READY = (state_q == IDLE);
  assign J         = j_q;
  assign K         = k_q;
  assign DONE      = done_q;
  assign ERR       = err_q;
  assign ERR_BITS  = err_bits_q;
  assign RETRY_CNT = retry_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench for jk_excitation_driver with a behavioural negedge JK bank and a completion scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_jk_excitation_driver;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [7:0] TGT = 8'h00;
  logic       TGT_VALID = 1'b0;
  logic       TGT_READY;
  logic [7:0] Q_FB;
  logic [7:0] J, K;
  logic       DONE, ERR;
  logic [7:0] ERR_BITS;
  logic [1:0] RETRY_CNT;

  logic [7:0] bank_q = 8'h00;
  logic [7:0] stuck  = 8'h00;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic [7:0] tgt;
    logic       err;
    logic [7:0] err_bits;
    logic [1:0] retry;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [7:0] tgt;
    logic [7:0] stuck;
    logic [7:0] j;
    logic [7:0] k;
    logic [1:0] retry;
    logic       err;
    logic [7:0] err_bits;
    logic [7:0] q;
  } vec_t;
  vec_t vecs[5];

  jk_excitation_driver #(.WIDTH(8), .MAX_RETRY(3)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .TGT       (TGT),
    .TGT_VALID (TGT_VALID),
    .TGT_READY (TGT_READY),
    .Q_FB      (Q_FB),
    .J         (J),
    .K         (K),
    .DONE      (DONE),
    .ERR       (ERR),
    .ERR_BITS  (ERR_BITS),
    .RETRY_CNT (RETRY_CNT)
  );

  always #5 CLK = ~CLK;

  assign Q_FB = bank_q;

  // Behavioural JK bank captured on negedge; stuck bits are forced to 0.
  always @(negedge CLK) begin
    logic [7:0] nxt;
    nxt = bank_q;
    for (int i = 0; i < 8; i++) begin
      case ({J[i], K[i]})
        2'b01:   nxt[i] = 1'b0;
        2'b10:   nxt[i] = 1'b1;
        2'b11:   nxt[i] = ~bank_q[i];
        default: nxt[i] = bank_q[i];
      endcase
    end
    bank_q <= nxt & ~stuck;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    else pass_cnt++;
  endtask

  // Completion monitor: every DONE/ERR pulse pops the oldest expected write.
  always @(posedge CLK) begin
    sb_t e;
    #1;
    if (DONE || ERR) begin
      chk("done_err_exclusive", 32'(DONE & ERR), 0);
      if (sb_q.size() == 0) begin
        chk("unexpected_completion", 32'(DONE | ERR), 0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_err", 32'(ERR), 32'(e.err));
        chk("sb_done", 32'(DONE), 32'(!e.err));
        chk("sb_retry", 32'(RETRY_CNT), 32'(e.retry));
        chk("sb_err_bits", 32'(ERR_BITS), e.err ? 32'(e.err_bits) : 0);
        chk("sb_ready_in_completion", 32'(TGT_READY), 1);
      end
    end
  end

  task automatic wait_done(output int n);
    n = 0;
    while (!(DONE || ERR) && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
  endtask

  task automatic do_write(input vec_t v);
    int n;
    stuck = v.stuck;
    TGT = v.tgt;
    TGT_VALID = 1'b1;
    sb_q.push_back('{v.tgt, v.err, v.err_bits, v.retry});
    @(posedge CLK); #1;
    TGT_VALID = 1'b0;
    chk("accept_j", 32'(J), 32'(v.j));
    chk("accept_k", 32'(K), 32'(v.k));
    chk("busy_not_ready", 32'(TGT_READY), 0);
    wait_done(n);
    chk("latency", n, 32'(1 + v.retry));
    chk("q_after", 32'(Q_FB), 32'(v.q));
  endtask

  initial begin
    int n;
    // tgt, stuck, J, K, retry, err, err_bits, final Q
`ifdef JK_TOGGLE_PREF_EN
    vecs[0] = '{8'hA5, 8'h00, 8'hA5, 8'hA5, 2'd0, 1'b0, 8'h00, 8'hA5};
    vecs[1] = '{8'h5A, 8'h00, 8'hFF, 8'hFF, 2'd0, 1'b0, 8'h00, 8'h5A};
    vecs[2] = '{8'hF0, 8'h00, 8'hAA, 8'hAA, 2'd0, 1'b0, 8'h00, 8'hF0};
    vecs[3] = '{8'hF0, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 8'h00, 8'hF0};
    vecs[4] = '{8'h01, 8'h01, 8'hF1, 8'hF1, 2'd3, 1'b1, 8'h01, 8'h00};
`else
    vecs[0] = '{8'hA5, 8'h00, 8'hA5, 8'h00, 2'd0, 1'b0, 8'h00, 8'hA5};
    vecs[1] = '{8'h5A, 8'h00, 8'h5A, 8'hA5, 2'd0, 1'b0, 8'h00, 8'h5A};
    vecs[2] = '{8'hF0, 8'h00, 8'hA0, 8'h0A, 2'd0, 1'b0, 8'h00, 8'hF0};
    vecs[3] = '{8'hF0, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 8'h00, 8'hF0};
    vecs[4] = '{8'h01, 8'h01, 8'h01, 8'hF0, 2'd3, 1'b1, 8'h01, 8'h00};
`endif

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ready", 32'(TGT_READY), 1);
    chk("rst_j", 32'(J), 0);
    chk("rst_k", 32'(K), 0);
    chk("rst_done", 32'(DONE), 0);
    chk("rst_err", 32'(ERR), 0);
    chk("rst_err_bits", 32'(ERR_BITS), 0);
    chk("rst_retry", 32'(RETRY_CNT), 0);
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // Table-driven writes, including the stuck-bit retry/ERR case
    for (int i = 0; i < 5; i++) begin
      do_write(vecs[i]);
      @(posedge CLK); #1;
    end
    stuck = 8'h00;

    // Back-to-back with TGT_VALID held: second accept lands in the first DONE cycle
    TGT = 8'h0F;
    TGT_VALID = 1'b1;
    sb_q.push_back('{8'h0F, 1'b0, 8'h00, 2'd0});
    @(posedge CLK); #1;
    chk("b2b_a_j", 32'(J), 32'h0F);
`ifdef JK_TOGGLE_PREF_EN
    chk("b2b_a_k", 32'(K), 32'h0F);
`else
    chk("b2b_a_k", 32'(K), 32'h00);
`endif
    TGT = 8'hF0;
    sb_q.push_back('{8'hF0, 1'b0, 8'h00, 2'd0});
    wait_done(n);
    chk("b2b_a_latency", n, 1);
    @(posedge CLK); #1;
    TGT_VALID = 1'b0;
    chk("b2b_done_one_cycle", 32'(DONE), 0);
    chk("b2b_second_accept_busy", 32'(TGT_READY), 0);
`ifdef JK_TOGGLE_PREF_EN
    chk("b2b_b_j", 32'(J), 32'hFF);
    chk("b2b_b_k", 32'(K), 32'hFF);
`else
    chk("b2b_b_j", 32'(J), 32'hF0);
    chk("b2b_b_k", 32'(K), 32'h0F);
`endif
    wait_done(n);
    chk("b2b_b_latency", n, 1);
    chk("b2b_q", 32'(Q_FB), 32'hF0);
    @(posedge CLK); #1;

    // Reset pulsed mid-DRIVE abandons the write
    TGT = 8'h3C;
    TGT_VALID = 1'b1;
    @(posedge CLK); #1;
    TGT_VALID = 1'b0;
`ifdef JK_TOGGLE_PREF_EN
    chk("rst_mid_j", 32'(J), 32'hCC);
    chk("rst_mid_k", 32'(K), 32'hCC);
`else
    chk("rst_mid_j", 32'(J), 32'h0C);
    chk("rst_mid_k", 32'(K), 32'hC0);
`endif
    RST_N = 1'b0;
    #1;
    chk("rst_async_j", 32'(J), 0);
    chk("rst_async_k", 32'(K), 0);
    chk("rst_async_ready", 32'(TGT_READY), 1);
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge CLK); #1;
      chk("post_rst_idle", {29'd0, DONE, ERR, TGT_READY}, 32'b001);
    end
    chk("sb_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
